epd_source_shifter: RTL and testbench
=====================================

Name: epd_source_shifter

Overview:
- Downstream companion to the EPD frame/timing controller; runs in the same 25 MHz XCL clock domain.
- Each line, it takes 4-bit grayscale pixels from the upstream frame-buffer reader through a valid/ready FIFO.
- It maps each pixel to a 2-bit source-driver code through a per-frame waveform LUT.
- It presents 4 pixels (8 bits) per XCL cycle on the source data bus, starting on the controller's line-start strobe.

Parameters:
- WIDTH, 1200, pixels per line; must be a multiple of 4.
- HIGH, 825, lines per frame.
- FIFO_DEPTH, 16, input word FIFO depth; must be a power of 2, at least 4.

Ports:
- clk  in  1  XCL-domain clock, 25 MHz.
- rst  in  1  asynchronous active-high reset.
- s_frame  in  1  frame-start pulse (same as controller S_Frame).
- s_line  in  1  line-start pulse; one cycle, issued by the controller one cycle before the XSTL-low window.
- wave_lut  in  32  frame waveform: bits [2g+1:2g] are the drive code for gray level g (00 none, 01 black, 10 white, 11 none).
- pix_data  in  16  four 4-bit pixels; pixel 0 is in [3:0].
- pix_valid  in  1  upstream word valid.
- pix_ready  out  1  FIFO not full.
- d_out  out  8  source data; pixel k code is in [2k+1:2k].
- d_en  out  1  d_out carries line data this cycle.
- line_done  out  1  one-cycle pulse after the last word of a line.
- frame_done  out  1  one-cycle pulse coincident with the HIGH-th line_done.
- underrun  out  1  sticky: FIFO was empty while shifting.
- overlap  out  1  sticky: s_line arrived while in SHIFT.

Behaviour:
- Reset values: d_out=0, d_en=0, line_done=0, frame_done=0, underrun=0, overlap=0, FIFO empty, counters 0, state IDLE.
- pix_ready resets to 0 and goes 1 on the first cycle after reset release.
- Constant WORDS = WIDTH/4 = 300. The word counter is 9 bits; the line counter is 12 bits.
- FIFO:
  - A write occurs when pix_valid && pix_ready.
  - Simultaneous read and write when full is not allowed; pix_ready is low when full.
  - A read and a write in the same cycle when empty writes only; there is no fall-through.
- LUT latch: on s_frame in IDLE, wave_lut is copied to an internal register, line counter is set to 0, and the state moves to WAIT_LINE.
- s_frame in any other state is ignored. The LUT is never changed mid-frame.
- States:
  - IDLE: waits for s_frame; s_line is ignored here.
  - WAIT_LINE: on s_line, go to SHIFT with word counter 0.
  - SHIFT: each cycle, pop one word if the FIFO is not empty.
    - Drive d_out = 4 LUT lookups of the popped word, registered; d_en=1.
    - If the FIFO is empty: d_out=8'h00, d_en=1, underrun sets. The word slot is still consumed, so the line length is fixed.
    - After WORDS cycles, go to LINE_END.
  - LINE_END: one cycle.
    - line_done=1, d_en=0, d_out=0; line counter increments.
    - If the line counter reaches HIGH: frame_done=1 and go to IDLE. Otherwise go to WAIT_LINE.
- Latency:
  - s_line sampled high at cycle T: first d_en=1 at T+1, last at T+300, line_done at T+301.
- s_line during SHIFT is ignored and sets overlap. s_line during LINE_END is also ignored but does not set overlap.
- underrun and overlap clear only on rst.
- Reset mid-line aborts immediately: outputs go to their reset values, and FIFO contents are discarded.
- d_out changes on the rising edge of clk; the source driver samples on the falling edge of XCL.

Decomposition:
- Shared EPD package holds:
  - WIDTH/HIGH defaults (also used by the frame controller).
  - Drive-code constants: NONE=2'b00, BLACK=2'b01, WHITE=2'b10.
  - WORDS computation.
  - State encoding.
- One sub-module: epd_pix_fifo, a synchronous FIFO, 16 bits wide × FIFO_DEPTH, with full/empty flags.
- The LUT mapping is inline combinational logic in the top module.

Test Plan:
- Prefill: load 300 words of 16'h0000 with wave_lut=32'h00000001, s_frame, then s_line at T → d_en high T+1..T+300, d_out=8'h55 throughout, line_done at T+301, underrun=0.
- Mapping: word 16'hF0A5 with wave_lut=32'h8000_0004 (g1→01, g15→10) → d_out=8'b10_00_00_00 for pixel order [5,A,0,F]; verify each pixel position independently.
- Underrun: only 100 words queued, then s_line → words 101..300 output 8'h00 with d_en=1, underrun=1 and stays 1, line_done still at T+301.
- Frame end: HIGH overridden to 3, three lines run → frame_done coincides with the third line_done; state returns to IDLE; a further s_line produces no d_en.
- Overlap/ignored controls: s_line at T+50 during SHIFT → overlap=1, timing unchanged; s_frame mid-line with a different wave_lut → codes unchanged for the rest of the frame.
- Reset mid-line: assert rst at T+150 → d_en=0, d_out=0, pix_ready=0 asynchronously; after release, pix_ready=1, FIFO empty, underrun=0, next s_frame/s_line sequence behaves as in the prefill scenario.

Source files
------------

// File: rtl/epd_source_shifter_pkg.sv
// Shared EPD definitions: panel geometry defaults (also used by the frame
// controller), source-driver drive codes, line word count and the source
// shifter state encoding.
package epd_source_shifter_pkg;

    localparam int unsigned EPD_WIDTH    = 1200;  // pixels per line
    localparam int unsigned EPD_HIGH     = 825;   // lines per frame

    localparam int unsigned PIX_W        = 4;     // bits per grayscale pixel
    localparam int unsigned PIX_PER_WORD = 4;     // pixels per FIFO word
    localparam int unsigned WCNT_W       = 9;     // word-in-line counter width
    localparam int unsigned LCNT_W       = 12;    // line-in-frame counter width

    // Source-driver drive codes (2'b11 also means no drive)
    localparam logic [1:0] DRV_NONE  = 2'b00;
    localparam logic [1:0] DRV_BLACK = 2'b01;
    localparam logic [1:0] DRV_WHITE = 2'b10;

    function automatic int unsigned words_per_line(input int unsigned width);
        return width / PIX_PER_WORD;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_SHIFT,
        ST_LINE_END
    } shift_state_e;

endpackage

// File: rtl/epd_pix_fifo.sv
// Synchronous word FIFO between the frame-buffer reader and the shifter.
// No fall-through: a word written while empty is readable the next cycle.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (pointers only)
//   wr_en_i/wr_data_i  push (ignored when full)
//   rd_en_i        pop (ignored when empty); rd_data_o shows the head word
//   full_o/empty_o occupancy flags
module epd_pix_fifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    // Extra MSB distinguishes full from empty when the indices match
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          do_wr, do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/epd_source_shifter.sv
// EPD source data shifter. Buffers 4-pixel gray words, maps every pixel
// through the per-frame waveform LUT and streams one 8-bit source word per
// XCL cycle for WIDTH/4 cycles after each line-start strobe.
// Ports:
//   clk_i, rst_i        XCL clock, async active-high reset
//   s_frame_i/s_line_i  frame / line start strobes from the timing controller
//   wave_lut_i          frame waveform, 2 bits per gray level
//   pix_data_i/pix_valid_i/pix_ready_o  upstream word stream
//   d_out_o/d_en_o      source data bus and its qualifier
//   line_done_o/frame_done_o  end-of-line / end-of-frame pulses
//   underrun_o/overlap_o      sticky error flags
module epd_source_shifter
    import epd_source_shifter_pkg::*;
#(
    parameter int unsigned WIDTH      = EPD_WIDTH,
    parameter int unsigned HIGH       = EPD_HIGH,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_frame_i,
    input  logic        s_line_i,
    input  logic [31:0] wave_lut_i,
    input  logic [15:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic [7:0]  d_out_o,
    output logic        d_en_o,
    output logic        line_done_o,
    output logic        frame_done_o,
    output logic        underrun_o,
    output logic        overlap_o
);
    localparam int unsigned    NUM_LANES = PIX_PER_WORD;
    localparam int unsigned    WORDS     = words_per_line(WIDTH);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
    localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(HIGH - 1);

    shift_state_e      state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [31:0]       lut_q, lut_d;
    logic [7:0]        d_out_q, d_out_d;
    logic              d_en_q, d_en_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              underrun_q, underrun_d;
    logic              overlap_q, overlap_d;
    logic              run_q;  // low in reset, high from the first edge after

    logic [15:0]       fifo_rd_data;
    logic              fifo_rd, fifo_full, fifo_empty;

    logic [NUM_LANES-1:0][PIX_W-1:0] pix_lane;
    logic [NUM_LANES-1:0][1:0]       code_lane;

    assign pix_ready_o = run_q && !fifo_full;

    epd_pix_fifo #(
        .DW    (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (pix_valid_i && pix_ready_o),
        .wr_data_i (pix_data_i),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Gray level g selects LUT bits [2g+1:2g]
    assign pix_lane = fifo_rd_data;
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign code_lane[k] = lut_q[{pix_lane[k], 1'b0} +: 2];
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        lcnt_d       = lcnt_q;
        lut_d        = lut_q;
        d_out_d      = {NUM_LANES{DRV_NONE}};
        d_en_d       = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q;
        overlap_d    = overlap_q;
        fifo_rd      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_frame_i) begin
                    lut_d   = wave_lut_i;
                    lcnt_d  = '0;
                    state_d = ST_WAIT_LINE;
                end
            end
            ST_WAIT_LINE: begin
                if (s_line_i) begin
                    wcnt_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Every cycle is a word slot, filled or not, so the line
                // length never depends on upstream throughput.
                d_en_d = 1'b1;
                if (fifo_empty) begin
                    underrun_d = 1'b1;
                end else begin
                    fifo_rd = 1'b1;
                    d_out_d = code_lane;
                end
                if (s_line_i) overlap_d = 1'b1;
                if (wcnt_q == LAST_WORD) state_d = ST_LINE_END;
                else                     wcnt_d  = wcnt_q + 1'b1;
            end
            ST_LINE_END: begin
                line_done_d = 1'b1;
                lcnt_d      = lcnt_q + 1'b1;
                if (lcnt_q == LAST_LINE) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LINE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            lcnt_q       <= '0;
            lut_q        <= '0;
            d_out_q      <= '0;
            d_en_q       <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            overlap_q    <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            lcnt_q       <= lcnt_d;
            lut_q        <= lut_d;
            d_out_q      <= d_out_d;
            d_en_q       <= d_en_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            overlap_q    <= overlap_d;
            run_q        <= 1'b1;
        end
    end

    assign d_out_o      = d_out_q;
    assign d_en_o       = d_en_q;
    assign line_done_o  = line_done_q;
    assign frame_done_o = frame_done_q;
    assign underrun_o   = underrun_q;
    assign overlap_o    = overlap_q;

endmodule

// File: tb/tb_epd_source_shifter.sv
// Directed bench for epd_source_shifter with HIGH=3 so a full frame is short.
// "At T+k" means the value after the k-th rising edge following the edge
// that sampled s_line; outputs are sampled on falling edges.
module tb_epd_source_shifter;
    import epd_source_shifter_pkg::*;

    localparam logic [7:0] ALL_BLACK = {4{DRV_BLACK}};  // 8'h55

    logic        clk = 1'b0, rst = 1'b1;
    logic        s_frame = 1'b0, s_line = 1'b0, pix_valid = 1'b0;
    logic [31:0] wave_lut = '0;
    logic [15:0] pix_data = '0;
    logic        pix_ready, d_en, line_done, frame_done, underrun, overlap;
    logic [7:0]  d_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] feed_q [$];
    bit          hs = 1'b0;

    always #5 clk = ~clk;

    epd_source_shifter #(
        .WIDTH      (1200),
        .HIGH       (3),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_frame_i    (s_frame),
        .s_line_i     (s_line),
        .wave_lut_i   (wave_lut),
        .pix_data_i   (pix_data),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .d_out_o      (d_out),
        .d_en_o       (d_en),
        .line_done_o  (line_done),
        .frame_done_o (frame_done),
        .underrun_o   (underrun),
        .overlap_o    (overlap)
    );

    // Upstream model: presents queued words; a handshake seen on one falling
    // edge retires the head word on the next.
    always @(negedge clk) begin
        if (hs && feed_q.size() > 0) feed_q.delete(0);
        if (feed_q.size() > 0 && !rst) begin
            pix_valid = 1'b1;
            pix_data  = feed_q[0];
        end else begin
            pix_valid = 1'b0;
            pix_data  = '0;
        end
        hs = pix_valid && pix_ready;
    end

    task automatic push_words(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) feed_q.push_back(w);
    endtask

    task automatic start_frame(input logic [31:0] lut);
        @(negedge clk); wave_lut = lut; s_frame = 1'b1;
        @(negedge clk); s_frame = 1'b0;
    endtask

    // Returns in the interval just after the edge T that sampled s_line
    task automatic fire_line();
        @(negedge clk); s_line = 1'b1;
        @(negedge clk); s_line = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (d_out !== 8'h00) begin
            errors++; $display("FAIL reset_d_out got %h want 00", d_out);
        end
        checks++;
        if ({d_en, line_done, frame_done, underrun, overlap, pix_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {d_en, line_done, frame_done, underrun, overlap, pix_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_before_edge got %b want 0", pix_ready);
        end
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || d_en !== 1'b0) begin
            errors++; $display("FAIL reset_ready_after got rdy=%b en=%b want 1/0", pix_ready, d_en);
        end
    endtask

    // 300 zero words, LUT maps gray 0 to black: every slot carries 8'h55.
    // Also drops an s_line into the LINE_END cycle, which must be ignored.
    task automatic test_prefill(input string tag);
        push_words(16'h0000, 300);
        start_frame(32'h0000_0001);
        repeat (30) @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++; $display("FAIL %s_full_ready got %b want 0", tag, pix_ready);
        end
        fire_line();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            checks++;
            if (d_en !== 1'b1 || d_out !== ALL_BLACK || line_done !== 1'b0) begin
                errors++;
                $display("FAIL %s_word%0d got en=%b d=%h ld=%b want 1/55/0",
                         tag, k, d_en, d_out, line_done);
            end
            if (k == 300) s_line = 1'b1;
        end
        @(negedge clk);
        s_line = 1'b0;
        checks++;
        if (line_done !== 1'b1 || d_en !== 1'b0 || d_out !== 8'h00 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_line_done got ld=%b en=%b d=%h fd=%b want 1/0/00/0",
                     tag, line_done, d_en, d_out, frame_done);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL %s_underrun got %b want 0", tag, underrun);
        end
        @(negedge clk);
        checks++;
        if (line_done !== 1'b0 || d_en !== 1'b0 || overlap !== 1'b0) begin
            errors++;
            $display("FAIL %s_line_end_sline got ld=%b en=%b ov=%b want 0/0/0",
                     tag, line_done, d_en, overlap);
        end
    endtask

    // s_line mid-line sets overlap without disturbing timing; s_frame with a
    // new LUT mid-frame must not change the codes.
    task automatic test_overlap();
        push_words(16'h0000, 300);
        repeat (30) @(negedge clk);
        fire_line();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            checks++;
            if (d_en !== 1'b1 || d_out !== ALL_BLACK) begin
                errors++; $display("FAIL ovl_word%0d got en=%b d=%h want 1/55", k, d_en, d_out);
            end
            if (k == 49) begin
                checks++;
                if (overlap !== 1'b0) begin
                    errors++; $display("FAIL ovl_before got %b want 0", overlap);
                end
                s_line = 1'b1;
            end
            if (k == 50) s_line = 1'b0;
            if (k == 51) begin
                checks++;
                if (overlap !== 1'b1) begin
                    errors++; $display("FAIL ovl_set got %b want 1", overlap);
                end
            end
            if (k == 99) begin wave_lut = 32'hAAAA_AAAA; s_frame = 1'b1; end
            if (k == 100) begin s_frame = 1'b0; wave_lut = 32'h0000_0001; end
        end
        @(negedge clk);
        checks++;
        if (line_done !== 1'b1 || d_en !== 1'b0 || overlap !== 1'b1) begin
            errors++;
            $display("FAIL ovl_line_done got ld=%b en=%b ov=%b want 1/0/1", line_done, d_en, overlap);
        end
    endtask

    // Third line of the HIGH=3 frame: frame_done with line_done, then IDLE.
    task automatic test_frame_end();
        push_words(16'h0000, 300);
        repeat (30) @(negedge clk);
        fire_line();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            checks++;
            if (d_en !== 1'b1 || d_out !== ALL_BLACK || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL fend_word%0d got en=%b d=%h fd=%b want 1/55/0", k, d_en, d_out, frame_done);
            end
        end
        @(negedge clk);
        checks++;
        if (line_done !== 1'b1 || frame_done !== 1'b1) begin
            errors++; $display("FAIL fend_pulse got ld=%b fd=%b want 1/1", line_done, frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL fend_pulse_width got %b want 0", frame_done);
        end
        fire_line();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (d_en !== 1'b0) begin
                errors++; $display("FAIL fend_idle_sline%0d got en=%b want 0", k, d_en);
            end
        end
    endtask

    // LUT 8000_0004: gray 1 -> black, gray 15 -> white, others none.
    task automatic test_mapping();
        logic [15:0] words [8];
        logic [7:0]  exp_d [8];
        logic [7:0]  want;
        words = '{16'hF0A5, 16'h000F, 16'h00F0, 16'h0F00,
                  16'hF000, 16'h1111, 16'h1F1F, 16'h2345};
        exp_d = '{8'h80, 8'h02, 8'h08, 8'h20, 8'h80, 8'h55, 8'h66, 8'h00};
        for (int i = 0; i < 8; i++) push_words(words[i], 1);
        push_words(16'h0000, 292);
        start_frame(32'h8000_0004);
        repeat (30) @(negedge clk);
        fire_line();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            want = (k <= 8) ? exp_d[k-1] : 8'h00;
            checks++;
            if (d_en !== 1'b1 || d_out !== want) begin
                errors++; $display("FAIL map_word%0d got en=%b d=%h want 1/%h", k, d_en, d_out, want);
            end
        end
        @(negedge clk);
        checks++;
        if (line_done !== 1'b1 || underrun !== 1'b0) begin
            errors++; $display("FAIL map_line_done got ld=%b ur=%b want 1/0", line_done, underrun);
        end
    endtask

    // Only 100 words: slots 101..300 are blank but still enabled.
    task automatic test_underrun();
        logic [7:0] want_d;
        logic       want_u;
        push_words(16'h1111, 100);
        repeat (30) @(negedge clk);
        fire_line();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            want_d = (k <= 100) ? 8'h55 : 8'h00;
            want_u = (k > 100);
            checks++;
            if (d_en !== 1'b1 || d_out !== want_d || underrun !== want_u) begin
                errors++;
                $display("FAIL urun_word%0d got en=%b d=%h ur=%b want 1/%h/%b",
                         k, d_en, d_out, underrun, want_d, want_u);
            end
        end
        @(negedge clk);
        checks++;
        if (line_done !== 1'b1 || underrun !== 1'b1) begin
            errors++; $display("FAIL urun_line_done got ld=%b ur=%b want 1/1", line_done, underrun);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL urun_sticky got %b want 1", underrun);
        end
    endtask

    task automatic test_reset_midline();
        push_words(16'h1111, 300);
        repeat (30) @(negedge clk);
        fire_line();
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            checks++;
            if (d_en !== 1'b1 || d_out !== 8'h55) begin
                errors++; $display("FAIL rmid_word%0d got en=%b d=%h want 1/55", k, d_en, d_out);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (d_en !== 1'b0 || d_out !== 8'h00 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got en=%b d=%h rdy=%b want 0/00/0", d_en, d_out, pix_ready);
        end
        feed_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || underrun !== 1'b0 || overlap !== 1'b0 || d_en !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release got rdy=%b ur=%b ov=%b en=%b want 1/0/0/0",
                     pix_ready, underrun, overlap, d_en);
        end
        // Any stale 16'h1111 word left in the FIFO would map to 00 here
        test_prefill("post_reset");
    endtask

    initial begin
        test_reset();
        test_prefill("prefill");
        test_overlap();
        test_frame_end();
        test_mapping();
        test_underrun();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
